// File: rtl/increment_scheduler.sv
// increment_scheduler
// Turns the raw "adjust" push-button into single-cycle increment strobes for
// the time counters. The button is synchronised and debounced; each accepted
// press gives one strobe. Holding the button starts auto-repeat: the first
// repeat follows a hold delay, and later ones come at a fixed repeat rate.
// Strobes are only produced while the control unit's increment-enable is high.
// A press that is already held when enable rises is ignored until the button
// is released.

module increment_scheduler #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned HOLD_CYCLES     = 25000000,
   parameter int unsigned REPEAT_CYCLES   = 5000000,
   parameter int unsigned CNT_W           = 26
) (
   input  logic i_Clock,
   input  logic i_Reset_n,
   input  logic i_Enable_Increment,
   input  logic i_Button,
   output logic o_Increment_Pulse,
   output logic o_Repeat_Active,
   output logic o_Button_Level
);

   // Terminal counts. Each counter restarts at zero, so an interval of N
   // cycles ends when the counter reaches N-1.
   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_REPEAT  = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_t;

   // Synchroniser flops
   logic sync1_q;
   logic sync2_q;

   // Debouncer state
   logic             db_q;
   logic             db_d;
   logic [CNT_W-1:0] dc_q;
   logic [CNT_W-1:0] dc_d;

   // Scheduler state
   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] ic_q;
   logic [CNT_W-1:0] ic_d;
   logic             pulse_q;
   logic             pulse_d;
   logic             rep_q;

   // Bring the asynchronous button into the clock domain
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= i_Button;
         sync2_q <= sync1_q;
      end
   end

   // Accept a new level only after it has been stable for the full debounce
   // window; any return to the current level restarts the count.
   always_comb begin
      db_d = db_q;
      dc_d = '0;
      if (sync2_q != db_q) begin
         if (dc_q == DB_LAST) begin
            db_d = sync2_q;
            dc_d = '0;
         end else begin
            dc_d = dc_q + CNT_ONE;
         end
      end
   end

   // Debouncer registers
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         db_q <= 1'b0;
         dc_q <= '0;
      end else begin
         db_q <= db_d;
         dc_q <= dc_d;
      end
   end

   // Scheduler next state. Within HOLD/REPEAT the order of tests gives the
   // precedence: enable low first, then release, then interval expiry, so a
   // strobe is never issued on a cycle that leaves the active states.
   always_comb begin
      state_d = state_q;
      ic_d    = ic_q;
      pulse_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            ic_d = '0;
            if (db_q) begin
               if (i_Enable_Increment) begin
                  state_d = ST_HOLD;
                  pulse_d = 1'b1;
               end else begin
                  state_d = ST_LOCKOUT;
               end
            end
         end
         ST_HOLD: begin
            if (!i_Enable_Increment) begin
               state_d = ST_LOCKOUT;
               ic_d    = '0;
            end else if (!db_q) begin
               state_d = ST_IDLE;
               ic_d    = '0;
            end else if (ic_q == HOLD_LAST) begin
               state_d = ST_REPEAT;
               pulse_d = 1'b1;
               ic_d    = '0;
            end else begin
               ic_d = ic_q + CNT_ONE;
            end
         end
         ST_REPEAT: begin
            if (!i_Enable_Increment) begin
               state_d = ST_LOCKOUT;
               ic_d    = '0;
            end else if (!db_q) begin
               state_d = ST_IDLE;
               ic_d    = '0;
            end else if (ic_q == REP_LAST) begin
               pulse_d = 1'b1;
               ic_d    = '0;
            end else begin
               ic_d = ic_q + CNT_ONE;
            end
         end
         ST_LOCKOUT: begin
            // A held press must be released before it can count again
            ic_d = '0;
            if (!db_q) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ic_d    = '0;
         end
      endcase
   end

   // Scheduler registers; strobe and repeat flag are registered with the state
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q <= ST_IDLE;
         ic_q    <= '0;
         pulse_q <= 1'b0;
         rep_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ic_q    <= ic_d;
         pulse_q <= pulse_d;
         rep_q   <= (state_d == ST_REPEAT);
      end
   end

   assign o_Increment_Pulse = pulse_q;
   assign o_Repeat_Active   = rep_q;
   assign o_Button_Level    = db_q;

endmodule

// File: tb/tb_increment_scheduler.sv
// Bench for increment_scheduler with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10,
// REPEAT_CYCLES=3. Expected strobe edge numbers are queued when a scenario
// drives its stimulus; a monitor pops one entry per observed strobe.

module tb_increment_scheduler;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic en    = 1'b1;
   logic btn   = 1'b0;
   logic pulse;
   logic rep;
   logic lvl;

   int checks   = 0;
   int failures = 0;
   int ecnt     = 0;   // number of rising edges so far
   int t0       = 0;   // absolute index of scenario edge 0
   int q[$];           // expected strobe edges, relative to t0

   increment_scheduler #(
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES    (10),
      .REPEAT_CYCLES  (3),
      .CNT_W          (8)
   ) dut (
      .i_Clock           (clk),
      .i_Reset_n         (rst_n),
      .i_Enable_Increment(en),
      .i_Button          (btn),
      .o_Increment_Pulse (pulse),
      .o_Repeat_Active   (rep),
      .o_Button_Level    (lvl)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ecnt <= ecnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Edge index (relative to scenario start) of the most recent rising edge
   function automatic int rel();
      return ecnt - 1 - t0;
   endfunction

   // Advance to the falling edge that follows scenario edge k
   task automatic goto(input int k);
      while (rel() < k) @(negedge clk);
   endtask

   // Called on a falling edge: the next rising edge becomes edge 0
   task automatic start();
      t0 = ecnt;
   endtask

   // Scoreboard: every observed strobe must match the next queued edge
   always @(negedge clk) begin
      if (pulse === 1'b1) begin
         if (q.size() == 0) check("unexpected_strobe", rel(), 32'hFFFF_FFFF);
         else check("strobe_edge", rel(), q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      // Reset state
      rst_n = 1'b0; en = 1'b1; btn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_pulse", pulse, 0);
      check("rst_rep", rep, 0);
      check("rst_lvl", lvl, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Single press, 9 cycles
      start(); btn = 1'b1; q.push_back(6);
      goto(4);  check("s1_lvl_e4", lvl, 0);
      goto(5);  check("s1_lvl_e5", lvl, 1);
      goto(8);  btn = 1'b0; check("s1_rep_e8", rep, 0);
      goto(13); check("s1_lvl_e13", lvl, 1);
      goto(14); check("s1_lvl_e14", lvl, 0);
      goto(25); check("s1_rep_end", rep, 0);
      check("s1_left", q.size(), 0);

      // Glitch rejection: two 3-cycle pulses, 2 cycles apart
      start(); btn = 1'b1;
      for (int k = 0; k < 20; k++) begin
         goto(k);
         if (k == 2 || k == 7) btn = 1'b0;
         if (k == 4) btn = 1'b1;
         check("s2_lvl", lvl, 0);
      end
      check("s2_left", q.size(), 0);

      // Auto-repeat, held 40 cycles
      start(); btn = 1'b1; q.push_back(6);
      for (int e = 16; e <= 43; e += 3) q.push_back(e);
      goto(15); check("s3_rep_e15", rep, 0);
      goto(16); check("s3_rep_e16", rep, 1);
      goto(39); btn = 1'b0;
      goto(44); check("s3_lvl_e44", lvl, 1);
      goto(45); check("s3_lvl_e45", lvl, 0); check("s3_rep_e45", rep, 1);
      goto(46); check("s3_rep_e46", rep, 0);
      goto(55); check("s3_left", q.size(), 0);

      // Enable drop while held, re-enable while held, then re-press
      start(); btn = 1'b1;
      q.push_back(6); q.push_back(16); q.push_back(19); q.push_back(51);
      goto(19); en = 1'b0;
      goto(21); check("s4_rep_lockout", rep, 0);
      goto(29); en = 1'b1;
      goto(34); btn = 1'b0;
      goto(40); check("s4_lvl_rel", lvl, 0);
      goto(44); btn = 1'b1;
      goto(52); btn = 1'b0;
      goto(70); check("s4_left", q.size(), 0);

      // Enable low at press, raised while held
      en = 1'b0;
      start(); btn = 1'b1; q.push_back(36);
      goto(9);  en = 1'b1;
      goto(15); check("s5_lvl_held", lvl, 1);
      goto(19); btn = 1'b0;
      goto(29); btn = 1'b1;
      goto(37); btn = 1'b0;
      goto(50); check("s5_left", q.size(), 0); check("s5_lvl_end", lvl, 0);

      // Asynchronous reset in REPEAT, released with the button held
      start(); btn = 1'b1;
      q.push_back(6); q.push_back(16); q.push_back(19); q.push_back(22);
      goto(22); check("s6_pre_pulse", pulse, 1); check("s6_pre_rep", rep, 1);
      #1 rst_n = 1'b0;
      #1;
      check("s6_async_pulse", pulse, 0);
      check("s6_async_rep", rep, 0);
      check("s6_async_lvl", lvl, 0);
      check("s6_phase1_left", q.size(), 0);
      @(negedge clk);
      check("s6_hold_lvl", lvl, 0);
      rst_n = 1'b1;
      start();
      q.push_back(6); q.push_back(16); q.push_back(19); q.push_back(22);
      goto(15); check("s6_rep_e15", rep, 0);
      goto(16); check("s6_rep_e16", rep, 1);
      goto(17); btn = 1'b0;
      goto(30); check("s6_left", q.size(), 0); check("s6_rep_end", rep, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
